led7seg_scan_rx: RTL
====================

LED7SEG_SCAN_RX -- requirements
Module: led7seg_scan_rx

Interface
REQ-001 SHALL have parameter C_STABLE, default 16: cycles a digit/segment code must hold unchanged before sampling (range 2..65535).
REQ-002 SHALL have parameter C_TIMEOUT, default 65536: maximum cycles between successive digit captures inside one frame.
REQ-003 SHALL have port CK_i  input  1  sole clock; all logic rises on posedge.
REQ-004 SHALL have port XARST_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ACT_DIGIT_i  input  4  external digit strobe, act H, one-hot; bit3 is the leftmost digit; asynchronous to CK_i.
REQ-006 SHALL have port SEG7_i  input  7  external segments {g,f,e,d,c,b,a}, act H; asynchronous to CK_i.
REQ-007 SHALL have port DAT_o  output  16  last complete frame, digit3 in [15:12] down to digit0 in [3:0].
REQ-008 SHALL have port VALID_o  output  1  one-cycle pulse when DAT_o/BLANK_o/DIG_ERR_o update.
REQ-009 SHALL have port BLANK_o  output  4  per-digit flag: all segments were off.
REQ-010 SHALL have port DIG_ERR_o  output  4  per-digit flag: segment code not in decode table.
REQ-011 SHALL have port SEQ_ERR_o  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-012 SHALL pass ACT_DIGIT_i and SEG7_i through two-flop synchronizers; all further timing counts from synchronized values.
REQ-013 SHALL run a stability counter: reset to 0 whenever synchronized {ACT_DIGIT,SEG7} differs from the previous cycle, else increment, saturating at C_STABLE.
REQ-014 SHALL treat a digit as "presented" when the counter reaches C_STABLE and ACT_DIGIT is exactly one-hot; all-zero or multi-hot strobes are gaps, never captured.
REQ-015 SHALL run FSM states IDLE, WAIT_D3, WAIT_D2, WAIT_D1, WAIT_D0; reset state IDLE.
REQ-016 IDLE -> WAIT_D3 immediately, clearing the partial-frame registers and the timeout counter.
REQ-017 In WAIT_Dn, a presentation of digit n SHALL capture the decoded nibble, blank flag and error flag into slot n and advance (WAIT_D0 -> WAIT_D3).
REQ-018 Each digit SHALL be captured once per presentation; re-arm only after the stability counter resets to 0.
REQ-019 In WAIT_D2/D1/D0, presentation of a digit other than the expected one SHALL discard the partial frame, pulse SEQ_ERR_o, and go to WAIT_D3; if that digit is digit3 it SHALL be captured as the new frame start in the same cycle.
REQ-020 In WAIT_D3, presentations of digits 2..0 SHALL be ignored silently (frame sync acquisition), with no SEQ_ERR_o.
REQ-021 Timeout counter SHALL increment in WAIT_D2/D1/D0 and clear on every capture; reaching C_TIMEOUT SHALL discard the frame, pulse SEQ_ERR_o, go to WAIT_D3.
REQ-022 Decode (gfedcba hex -> nibble): 3F-0, 06-1, 5B-2, 4F-3, 66-4, 6D-5, 7D-6, 27-7, 7F-8, 6F-9, 77-A, 7C-B, 39-C, 5E-D, 79-E, 71-F.
REQ-023 Code 00 SHALL yield nibble 0, blank=1, err=0; any other unlisted code nibble 0, blank=0, err=1.
REQ-024 On digit0 capture, DAT_o, BLANK_o, DIG_ERR_o SHALL update and VALID_o pulse on the next CK_i edge; outputs hold until the next complete frame.
REQ-025 Latency: input change to VALID_o = 2 (sync) + C_STABLE + 1 cycles for the digit0 presentation.

Reset
REQ-026 XARST_i low SHALL asynchronously force DAT_o=0, BLANK_o=0, DIG_ERR_o=0, VALID_o=0, SEQ_ERR_o=0, synchronizers=0, counters=0, FSM=IDLE.
REQ-027 Reset mid-frame SHALL discard the partial frame without SEQ_ERR_o.

Structure
REQ-028 Package led7seg_pkg SHALL hold the 16 segment-code constants, blank code, and FSM state type; shared with the existing driver.
REQ-029 Decoder SHALL be sub-module led7seg_seg_dec: SEG7 in -> nibble, blank, err; purely combinational.

Verification
REQ-030 C_STABLE=4, scan 8:0x06, 4:0x5B, 2:0x77, 1:0x71, each 20 cycles -> DAT_o=0x12AF, VALID_o one pulse, BLANK_o=0, DIG_ERR_o=0.
REQ-031 Digits 3,2 code 0x00, 1:0x77, 0:0x6D -> DAT_o=0x00A5, BLANK_o=4'b1100.
REQ-032 Digit1 code 0x01, others valid -> DIG_ERR_o=4'b0010, VALID_o pulses, nibble1=0.
REQ-033 Order 8,4,1 -> SEQ_ERR_o pulse on digit0 presentation, no VALID_o; next full 8,4,2,1 frame accepted.
REQ-034 Segment glitch 2 cycles wide (< C_STABLE) mid-digit -> no extra capture, frame value unchanged; XARST_i pulse after digit2 -> outputs 0, no SEQ_ERR_o, next frame valid.

Source files
------------

// File: rtl/led7seg_pkg.sv
// Shared 7-segment definitions: segment codes, blank code and scan FSM states.
package led7seg_pkg;

    // Index n holds the {g,f,e,d,c,b,a} pattern that displays hex digit n.
    localparam logic [15:0][6:0] SEG_CODE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h27, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_D3,
        ST_WAIT_D2,
        ST_WAIT_D1,
        ST_WAIT_D0
    } state_t;

endpackage

// File: rtl/led7seg_seg_dec.sv
// Combinational 7-segment pattern to hex nibble decoder.
module led7seg_seg_dec
    import led7seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       blank,
    output logic       err
);

    always_comb begin
        nib   = '0;
        blank = 1'b0;
        err   = 1'b1;
        if (seg == SEG_BLANK) begin
            blank = 1'b1;
            err   = 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg == SEG_CODE[i]) begin
                    nib = 4'(i);
                    err = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/led7seg_scan_rx.sv
// Receives a multiplexed 4-digit 7-segment scan and rebuilds the 16-bit value.
module led7seg_scan_rx
    import led7seg_pkg::*;
#(
    parameter int unsigned C_STABLE  = 16,
    parameter int unsigned C_TIMEOUT = 65536
) (
    input  logic        CK_i,
    input  logic        XARST_i,
    input  logic [3:0]  ACT_DIGIT_i,
    input  logic [6:0]  SEG7_i,
    output logic [15:0] DAT_o,
    output logic        VALID_o,
    output logic [3:0]  BLANK_o,
    output logic [3:0]  DIG_ERR_o,
    output logic        SEQ_ERR_o
);

    logic [3:0]       act_s1, act_s2;
    logic [6:0]       seg_s1, seg_s2;
    logic [15:0]      stb_cnt;
    logic [10:0]      last_key;
    logic [31:0]      tmo_cnt;
    state_t           state, state_nxt, adv_st;
    logic             diff, onehot, pres;
    logic [3:0]       cap, exp_dig;
    logic             clr, tmo_inc, done, seq_err;
    logic [3:0]       dec_nib;
    logic             dec_blank, dec_err;
    logic [3:0][3:0]  nib_q;
    logic [3:0]       blank_q, err_q;

    led7seg_seg_dec u_dec (
        .seg   (seg_s2),
        .nib   (dec_nib),
        .blank (dec_blank),
        .err   (dec_err)
    );

    assign diff   = {act_s1, seg_s1} != {act_s2, seg_s2};
    assign onehot = (act_s2 != 4'd0) && ((act_s2 & (act_s2 - 4'd1)) == 4'd0);
    // A code that returns after a short glitch is the same presentation.
    assign pres   = (stb_cnt == 16'(C_STABLE)) && onehot
                    && ({act_s2, seg_s2} != last_key);

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            act_s1   <= '0;
            act_s2   <= '0;
            seg_s1   <= '0;
            seg_s2   <= '0;
            stb_cnt  <= '0;
            last_key <= '0;
        end else begin
            act_s1 <= ACT_DIGIT_i;
            act_s2 <= act_s1;
            seg_s1 <= SEG7_i;
            seg_s2 <= seg_s1;
            if (diff)
                stb_cnt <= '0;
            else if (stb_cnt != 16'(C_STABLE))
                stb_cnt <= stb_cnt + 16'd1;
            if (pres)
                last_key <= {act_s2, seg_s2};
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        exp_dig = '0;
        adv_st  = ST_WAIT_D3;
        unique case (state)
            ST_WAIT_D2: begin exp_dig = 4'b0100; adv_st = ST_WAIT_D1; end
            ST_WAIT_D1: begin exp_dig = 4'b0010; adv_st = ST_WAIT_D0; end
            ST_WAIT_D0: begin exp_dig = 4'b0001; adv_st = ST_WAIT_D3; end
            default:    ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cap       = '0;
        clr       = 1'b0;
        tmo_inc   = 1'b0;
        done      = 1'b0;
        seq_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                state_nxt = ST_WAIT_D3;
                clr       = 1'b1;
            end
            ST_WAIT_D3: begin
                if (pres && act_s2[3]) begin
                    cap       = 4'b1000;
                    state_nxt = ST_WAIT_D2;
                end
            end
            default: begin
                tmo_inc = 1'b1;
                if (pres && act_s2 == exp_dig) begin
                    cap       = exp_dig;
                    state_nxt = adv_st;
                    done      = (state == ST_WAIT_D0);
                end else if (pres) begin
                    // Out-of-order digit: drop the frame, digit3 restarts it.
                    seq_err = 1'b1;
                    clr     = 1'b1;
                    if (act_s2[3]) begin
                        cap       = 4'b1000;
                        state_nxt = ST_WAIT_D2;
                    end else begin
                        state_nxt = ST_WAIT_D3;
                    end
                end else if (tmo_cnt >= 32'(C_TIMEOUT)) begin
                    seq_err   = 1'b1;
                    clr       = 1'b1;
                    state_nxt = ST_WAIT_D3;
                end
            end
        endcase
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            nib_q     <= '0;
            blank_q   <= '0;
            err_q     <= '0;
            tmo_cnt   <= '0;
            DAT_o     <= '0;
            BLANK_o   <= '0;
            DIG_ERR_o <= '0;
            VALID_o   <= 1'b0;
            SEQ_ERR_o <= 1'b0;
        end else begin
            if (clr) begin
                nib_q   <= '0;
                blank_q <= '0;
                err_q   <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                if (cap[i]) begin
                    nib_q[i]   <= dec_nib;
                    blank_q[i] <= dec_blank;
                    err_q[i]   <= dec_err;
                end
            end
            if (clr || cap != 4'd0)
                tmo_cnt <= '0;
            else if (tmo_inc)
                tmo_cnt <= tmo_cnt + 32'd1;
            VALID_o   <= done;
            SEQ_ERR_o <= seq_err;
            if (done) begin
                DAT_o     <= {nib_q[3], nib_q[2], nib_q[1], dec_nib};
                BLANK_o   <= {blank_q[3:1], dec_blank};
                DIG_ERR_o <= {err_q[3:1], dec_err};
            end
        end
    end

endmodule
